// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide unit with a fixed-latency sequencer for the EX stage.
module muldiv_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 64;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                sgn_q, sgn_d;

  logic                accept;
  logic [PROD_W-1:0]   prod;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag, den;
  logic [DATA_W-1:0]   q_mag, r_mag;
  logic [DATA_W-1:0]   quot, rem;

  assign accept = start & ~req & (state_q == S_IDLE);

  // Product and sign/magnitude divide of the latched operands.
  always_comb begin
    prod  = '0;
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = '0;
    b_mag = '0;
    den   = '0;
    q_mag = '0;
    r_mag = '0;
    quot  = '0;
    rem   = '0;
    if (sgn_q) begin
      prod = PROD_W'($signed(a_q)) * PROD_W'($signed(b_q));
    end else begin
      prod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    end
    a_neg = sgn_q & a_q[DATA_W-1];
    b_neg = sgn_q & b_q[DATA_W-1];
    a_mag = a_neg ? (~a_q + DATA_W'(1)) : a_q;
    b_mag = b_neg ? (~b_q + DATA_W'(1)) : b_q;
    // Zero divisor never commits; substitute 1 so the divider stays defined.
    den   = (b_mag == '0) ? DATA_W'(1) : b_mag;
    q_mag = a_mag / den;
    r_mag = a_mag % den;
    quot  = (a_neg ^ b_neg) ? (~q_mag + DATA_W'(1)) : q_mag;
    rem   = a_neg ? (~r_mag + DATA_W'(1)) : r_mag;
  end

  // Sequencer next-state, countdown, operand latch and HI/LO commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_DIV);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = prod[PROD_W-1:DATA_W];
          lo_d    = prod[DATA_W-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign out  = hilo_sel ? hi_q : lo_q;

endmodule
